// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared FSM states, settle length and pair-selection helper for the RO PUF controller
package ro_puf_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, STORE, COMPARE, FINISH} state_t;

    localparam int SETTLE_CYCLES = 16;

    // Permuted mode adds 1..num_ro-1, so an oscillator is never paired with itself
    function automatic int pair_idx(int i, logic mode, int challenge, int num_ro);
        return mode ? (i + 1 + challenge % (num_ro - 1)) % num_ro : (i + 1) % num_ro;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronises one oscillator and counts its rising edges, saturating at all-ones
module ro_edge_counter #(
    parameter int CNT_W = 24
) (
    input  logic             count_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             ro_in,
    output logic [CNT_W-1:0] count
);

    // sync[1:0] is the 2-flop synchroniser, sync[2] the previous sample for edge detect
    logic [2:0] sync;

    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            count <= '0;
        end else begin
            sync <= {sync[1:0], ro_in};
            if (clear) count <= '0;
            else if (en && sync[1] && !sync[2] && count != '1) count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: sweeps a ring-oscillator bank, compares edge counts pairwise and majority-votes the response
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO = 16,
    parameter int CNT_W  = 24,
    parameter int WIN_W  = 20,
    parameter int CHAL_W = 8,
    parameter int VOTES  = 3
) (
    input  logic              count_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    input  logic              mode,
    input  logic [WIN_W-1:0]  window,
    output logic [NUM_RO-1:0] ro_en,
    input  logic [NUM_RO-1:0] ro_in,
    output logic              busy,
    output logic              done,
    output logic [NUM_RO-1:0] response
);

    localparam int RW = $clog2(NUM_RO);
    localparam int VW = $clog2(VOTES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [NUM_RO-1:0] ONE = {{(NUM_RO - 1){1'b0}}, 1'b1};

    state_t            state;
    logic [RW-1:0]     ro;
    logic [VW-1:0]     pass;
    logic [SW-1:0]     sc;
    logic [WIN_W-1:0]  wc, win_q;
    logic [CHAL_W-1:0] chal_q;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_arr [NUM_RO];
    logic [VW-1:0]     votes [NUM_RO];
    logic [NUM_RO-1:0] gt;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .count_clk(count_clk),
        .reset(reset),
        .clear(state == SETTLE),
        .en(state == MEASURE),
        .ro_in(ro_in[ro]),
        .count(cnt)
    );

    for (genvar i = 0; i < NUM_RO; i++) begin : g_cmp
        assign gt[i] = cnt_arr[i] > cnt_arr[RW'(pair_idx(i, mode_q, int'(chal_q), NUM_RO))];
    end

    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ro       <= '0;
            pass     <= '0;
            sc       <= '0;
            wc       <= '0;
            win_q    <= '0;
            chal_q   <= '0;
            mode_q   <= 1'b0;
            ro_en    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
            for (int k = 0; k < NUM_RO; k++) begin
                cnt_arr[k] <= '0;
                votes[k]   <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        chal_q <= challenge;
                        mode_q <= mode;
                        win_q  <= window == '0 ? WIN_W'(1) : window;
                        for (int k = 0; k < NUM_RO; k++) votes[k] <= '0;
                        ro    <= '0;
                        pass  <= '0;
                        sc    <= '0;
                        ro_en <= ONE;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    sc <= sc + 1'b1;
                    if (sc == SW'(SETTLE_CYCLES - 1)) begin
                        wc    <= WIN_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    wc <= wc + 1'b1;
                    if (wc == win_q) begin
                        ro_en <= '0;
                        state <= STORE;
                    end
                end
                STORE: begin
                    cnt_arr[ro] <= cnt;
                    if (ro == RW'(NUM_RO - 1)) state <= COMPARE;
                    else begin
                        ro    <= ro + 1'b1;
                        sc    <= '0;
                        ro_en <= ONE << (ro + 1'b1);
                        state <= SETTLE;
                    end
                end
                COMPARE: begin
                    for (int k = 0; k < NUM_RO; k++) if (gt[k]) votes[k] <= votes[k] + 1'b1;
                    if (pass == VW'(VOTES - 1)) state <= FINISH;
                    else begin
                        pass  <= pass + 1'b1;
                        ro    <= '0;
                        sc    <= '0;
                        ro_en <= ONE;
                        state <= SETTLE;
                    end
                end
                FINISH: begin
                    for (int k = 0; k < NUM_RO; k++) response[k] <= votes[k] > VW'(VOTES / 2);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
